ram_prog_loader: RTL and testbench
==================================

# ram_prog_loader

Byte-stream program loader that acts as the initiator for the dual-port program/data RAM. It accepts a length-prefixed little-endian byte stream, for example from the UART receiver, and packs it into 32-bit words. It writes those words through the RAM write port, then reads every word back through the RAM read port and compares checksums. The result is one `done` pulse with a pass/fail flag; the core is held off the RAM while `busy` is high.

## Interface
- `DW`, 32, data word width; only 32 is supported.
- `AW`, 12, RAM address width; capacity is 2^AW words.
- `BASE`, 0, first word address written.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse; begins a load when in IDLE; ignored otherwise.
- `s_valid`  in  1  byte-stream valid.
- `s_data`  in  8  byte-stream data.
- `s_ready`  out  1  byte accepted on the cycle where `s_valid && s_ready`.
- `w_en`  out  1  RAM write enable, one-cycle pulse per word.
- `w_addr`  out  AW  RAM write address.
- `w_data`  out  DW  RAM write data.
- `r_en`  out  1  RAM read enable.
- `r_addr`  out  AW  RAM read address.
- `r_data_i`  in  DW  RAM read data, valid one cycle after `r_en` (registered RAM).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  result flag; updated with `done`, held until the next accepted `start`.

## Operation
- **States:** IDLE, LEN, DATA, VERIFY, CHECK, DONE.
- **IDLE:** `s_ready`=0. On `start`: go to LEN; clear byte counter, word index, `sum_w`, `sum_r` and `err`.
- **LEN:** `s_ready`=1. Accept 2 bytes as N[15:0], little-endian (first byte is N[7:0]).
  - N=0: go to DONE, `err`=0, no RAM access.
  - N > 2^AW: go to DONE, `err`=1, no RAM access.
  - Otherwise: go to DATA.
- **DATA:** `s_ready`=1. Bytes pack little-endian: the first byte of each group of 4 goes to word[7:0].
  - On acceptance of the 4th byte of word k, the next cycle drives `w_en`=1, `w_addr`=(BASE+k) mod 2^AW, `w_data`=word.
  - `sum_w` += word, mod 2^32.
  - Byte acceptance continues back-to-back during the write cycle.
  - After the 4th byte of word N-1: `s_ready` drops to 0 the following cycle, then go to VERIFY.
- **VERIFY:** issue `r_en`=1 with `r_addr`=(BASE+j) mod 2^AW for j=0..N-1, one per cycle, no gaps.
  - A `pend` flag marks a read in flight. Each cycle with `pend`=1 does `sum_r` += `r_data_i`.
  - After the last read, go to CHECK.
- **CHECK:** absorb the final read data, then go to DONE.
- **DONE:** `done`=1 for one cycle, `err`=(`sum_r` != `sum_w`). Return to IDLE.
- **Idle outputs:** `w_en` and `r_en` are 0 outside their issuing cycles. `w_addr`, `w_data` and `r_addr` hold their last values.
- **Ignored input:** `s_valid` in IDLE, VERIFY, CHECK or DONE is not consumed.
- **Reset:** at any time, including mid-load, return to IDLE.
  - The partial word is discarded.
  - Words already written stay in RAM.
  - No `done` pulse is produced.

## Timing
- **Reset values:** `s_ready`, `w_en`, `r_en`, `busy`, `done`, `err` = 0; `w_addr`, `w_data`, `r_addr` = 0.
- **Start:** `start` sampled in cycle S gives `busy`=1 and `s_ready`=1 from S+1.
- **Write latency:** 4th byte of word k accepted in cycle T gives `w_en` in T+1.
- **Completion, last byte accepted in cycle T (N≥1):**
  - `w_en` for the last word at T+1.
  - `r_en` at T+2 … T+1+N.
  - Last read data added at T+2+N (CHECK).
  - `done` at T+3+N.
- **Early termination:** N=0 or length error, with the 2nd length byte accepted in cycle L, gives `done` at L+2.
- **Back-pressure:** `s_valid` gaps stall packing indefinitely; there is no timeout.
- **Restart:** `start` during the `done` cycle is ignored. The earliest restart is the cycle after `done`.

## Test plan
- **Single word:** `start`, bytes 01 00 | 78 56 34 12 → one `w_en` with `w_addr`=0, `w_data`=0x12345678. One `r_en` at addr 0. `done` 4 cycles after the last byte, `err`=0.
- **Back-to-back stream:** N=3, words 0x11111111, 0x22222222, 0xFFFFFFFF, `s_valid` held high → writes at addrs 0,1,2, `sum_w`=0x33333332, 3 consecutive reads, `err`=0.
- **Zero and oversize length:** N=0 → `done` with `err`=0, no `w_en`/`r_en`. N=0x1001 with AW=12 → `done` with `err`=1, no RAM access.
- **Wrap and mismatch:** BASE=0xFFE, N=3 → `w_addr` sequence 0xFFE, 0xFFF, 0x000. Forcing `r_data_i`=0 on the second read → `err`=1.
- **Reset mid-load:** `rst_n`=0 after 2 data bytes of word 0 → all outputs 0 next cycle, no `w_en`. A new `start` then loads cleanly from addr BASE.
- **Ignored inputs:** `start` pulsed during DATA and `s_valid` driven in IDLE → no state change and no byte consumed (`s_ready`=0 in IDLE).

Source files
------------

// File: rtl/ram_prog_loader.sv
// Loads a length-prefixed little-endian byte stream into a 32-bit RAM, then reads
// every word back and compares the running checksums of the writes and the reads.
//
// state  | meaning
// IDLE   | waiting for start, RAM untouched
// LEN    | collecting the 16-bit word count, low byte first
// DATA   | packing bytes into words, one RAM write per completed word
// VERIFY | issuing one read per cycle for every written word
// CHECK  | absorbing the last read, settling err
// DONE   | one-cycle done pulse
module ram_prog_loader #(
  parameter int DW   = 32,
  parameter int AW   = 12,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          w_en,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          r_en,
  output logic [AW-1:0] r_addr,
  input  logic [DW-1:0] r_data_i,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_VERIFY, S_CHECK, S_DONE
  } state_t;

  localparam int unsigned MAX_WORDS = 1 << AW;

  state_t        state, state_nx;
  logic [1:0]    byte_cnt;
  logic [15:0]   len;
  logic [15:0]   wr_idx;
  logic [15:0]   rd_idx;
  logic [23:0]   word_lo;
  logic [DW-1:0] sum_w;
  logic [DW-1:0] sum_r;
  logic          pend;
  logic          len_err;

  logic          accept;
  logic [15:0]   len_nx;
  logic          len_bad;
  logic [DW-1:0] word_full;
  logic          last_word;

  assign s_ready   = (state == S_LEN) || (state == S_DATA);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = s_valid && s_ready;
  assign len_nx    = {s_data, len[7:0]};
  assign len_bad   = 32'(len_nx) > MAX_WORDS;
  assign word_full = {s_data, word_lo};
  assign last_word = (wr_idx == len - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Zero and oversize lengths pass through CHECK so done lands two cycles after the length.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LEN;
      S_LEN:    if (accept && byte_cnt == 2'd1)
                  state_nx = (len_nx == 16'd0 || len_bad) ? S_CHECK : S_DATA;
      S_DATA:   if (accept && byte_cnt == 2'd3 && last_word) state_nx = S_VERIFY;
      S_VERIFY: if (rd_idx == len) state_nx = S_CHECK;
      S_CHECK:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      len      <= 16'd0;
      wr_idx   <= 16'd0;
      rd_idx   <= 16'd0;
      word_lo  <= 24'd0;
      sum_w    <= '0;
      sum_r    <= '0;
      pend     <= 1'b0;
      len_err  <= 1'b0;
      err      <= 1'b0;
      w_en     <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      r_en     <= 1'b0;
      r_addr   <= '0;
    end else begin
      w_en <= 1'b0;
      r_en <= 1'b0;
      pend <= r_en;
      if (pend) sum_r <= sum_r + r_data_i;
      case (state)
        S_IDLE: begin
          if (start) begin
            byte_cnt <= 2'd0;
            wr_idx   <= 16'd0;
            rd_idx   <= 16'd0;
            sum_w    <= '0;
            sum_r    <= '0;
            err      <= 1'b0;
            len_err  <= 1'b0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (byte_cnt == 2'd0) begin
              len[7:0] <= s_data;
              byte_cnt <= 2'd1;
            end else begin
              len      <= len_nx;
              len_err  <= len_bad;
              byte_cnt <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_lo[7:0]   <= s_data;
              2'd1: word_lo[15:8]  <= s_data;
              2'd2: word_lo[23:16] <= s_data;
              default: begin
                w_en   <= 1'b1;
                w_addr <= AW'(BASE + wr_idx);
                w_data <= word_full;
                sum_w  <= sum_w + word_full;
                wr_idx <= wr_idx + 16'd1;
              end
            endcase
          end
        end
        S_VERIFY: begin
          if (rd_idx != len) begin
            r_en   <= 1'b1;
            r_addr <= AW'(BASE + rd_idx);
            rd_idx <= rd_idx + 16'd1;
          end
        end
        S_CHECK: err <= len_err || ((pend ? sum_r + r_data_i : sum_r) != sum_w);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_prog_loader.sv
// Self-checking bench: two loaders (BASE 0 and BASE 0xFFE) share one stimulus stream,
// each backed by a registered RAM model; results are compared to an abstract load model.
module tb_ram_prog_loader;

  localparam int AW     = 12;
  localparam int DEPTH  = 1 << AW;
  localparam int BASE_B = 'hFFE;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic s_ready_a, w_en_a, r_en_a, busy_a, done_a, err_a;
  logic [AW-1:0] w_addr_a, r_addr_a;
  logic [31:0] w_data_a, r_data_a;
  logic s_ready_b, w_en_b, r_en_b, busy_b, done_b, err_b;
  logic [AW-1:0] w_addr_b, r_addr_b;
  logic [31:0] w_data_b, r_data_b;

  ram_prog_loader #(.DW(32), .AW(AW), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_a), .w_en(w_en_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .r_en(r_en_a), .r_addr(r_addr_a), .r_data_i(r_data_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  ram_prog_loader #(.DW(32), .AW(AW), .BASE(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .w_en(w_en_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .r_en(r_en_b), .r_addr(r_addr_b), .r_data_i(r_data_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered RAM models; corrupt_rd zeroes the chosen read of the current load.
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  int rd_tot_a = 0, rd_tot_b = 0, rd_base_a = 0, rd_base_b = 0, corrupt_rd = -1;

  always @(posedge clk) begin
    if (w_en_a) mem_a[w_addr_a] <= w_data_a;
    if (w_en_b) mem_b[w_addr_b] <= w_data_b;
    if (r_en_a) begin
      r_data_a <= (rd_tot_a - rd_base_a == corrupt_rd) ? 32'h0 : mem_a[r_addr_a];
      rd_tot_a <= rd_tot_a + 1;
    end
    if (r_en_b) begin
      r_data_b <= (rd_tot_b - rd_base_b == corrupt_rd) ? 32'h0 : mem_b[r_addr_b];
      rd_tot_b <= rd_tot_b + 1;
    end
  end

  ev_t w_a[$], w_b[$], r_a[$], r_b[$];
  int acc_q[$], done_q[$], doneb_q[$];
  logic derr_a[$], derr_b[$];

  always @(negedge clk) begin
    if (w_en_a) w_a.push_back('{cyc, int'(w_addr_a), w_data_a});
    if (w_en_b) w_b.push_back('{cyc, int'(w_addr_b), w_data_b});
    if (r_en_a) r_a.push_back('{cyc, int'(r_addr_a), 32'h0});
    if (r_en_b) r_b.push_back('{cyc, int'(r_addr_b), 32'h0});
    if (s_valid && s_ready_a) acc_q.push_back(cyc);
    if (done_a) begin done_q.push_back(cyc);  derr_a.push_back(err_a); end
    if (done_b) begin doneb_q.push_back(cyc); derr_b.push_back(err_b); end
  end

  int asserts = 0, fails = 0;
  int wb, wbb, rb, rbb, ab, db, dbb;

  function automatic bq_t make_bytes(input int n, input logic [31:0] words[$]);
    bq_t q;
    logic [15:0] nn;
    nn = 16'(n);
    q.push_back(nn[7:0]);
    q.push_back(nn[15:8]);
    foreach (words[k]) for (int i = 0; i < 4; i++) q.push_back(words[k][8*i +: 8]);
    return q;
  endfunction

  task automatic mark();
    wb = w_a.size(); wbb = w_b.size(); rb = r_a.size(); rbb = r_b.size();
    ab = acc_q.size(); db = done_q.size(); dbb = doneb_q.size();
    rd_base_a = rd_tot_a; rd_base_b = rd_tot_b;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
    bit acc;
    acc = 1'b0;
    repeat (gap) begin s_valid = 1'b0; @(posedge clk); #1; end
    s_valid = 1'b1; s_data = b; start = with_start;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk); acc = s_ready_a;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!acc) begin
      asserts++; fails++;
      $display("FAIL byte_accept: byte %0h not taken within 100 cycles, required s_ready=1", b);
    end
  endtask

  task automatic run_load(input bq_t bytes, input int gap_max, input int corrupt, input int start_at);
    int t;
    mark();
    corrupt_rd = corrupt;
    pulse_start();
    foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(gap_max, 0)), i == start_at);
    s_valid = 1'b0;
    t = 0;
    while (done_q.size() == db && t < 20000) begin @(negedge clk); t++; end
    if (done_q.size() == db) begin
      asserts++; fails++;
      $display("FAIL done_timeout: no done after %0d cycles, required one done pulse", t);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    asserts++;
    if ({s_ready_a, w_en_a, r_en_a, busy_a, done_a, err_a} !== 6'b0)
      begin fails++; $display("FAIL reset_ctrl_a: got %b required 000000", {s_ready_a, w_en_a, r_en_a, busy_a, done_a, err_a}); end
    asserts++;
    if ({s_ready_b, w_en_b, r_en_b, busy_b, done_b, err_b} !== 6'b0)
      begin fails++; $display("FAIL reset_ctrl_b: got %b required 000000", {s_ready_b, w_en_b, r_en_b, busy_b, done_b, err_b}); end
    asserts++;
    if (w_addr_a !== '0 || w_data_a !== '0 || r_addr_a !== '0 || w_addr_b !== '0 || w_data_b !== '0 || r_addr_b !== '0)
      begin fails++; $display("FAIL reset_bus: got %h %h %h / %h %h %h required all 0", w_addr_a, w_data_a, r_addr_a, w_addr_b, w_data_b, r_addr_b); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    bq_t b;
    int last;
    b = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_load(b, 0, -1, -1);
    last = acc_q[ab + 5];
    asserts++;
    if (acc_q.size() - ab != 6) begin fails++; $display("FAIL sw_bytes: got %0d accepted required 6", acc_q.size() - ab); end
    asserts++;
    if (w_a.size() - wb != 1 || w_a[wb].addr != 0 || w_a[wb].data !== 32'h12345678)
      begin fails++; $display("FAIL sw_write: got n=%0d addr=%0h data=%h required 1 0 12345678", w_a.size() - wb, w_a[wb].addr, w_a[wb].data); end
    asserts++;
    if (w_a[wb].cyc != last + 1) begin fails++; $display("FAIL sw_write_lat: got cyc %0d required %0d", w_a[wb].cyc, last + 1); end
    asserts++;
    if (r_a.size() - rb != 1 || r_a[rb].addr != 0 || r_a[rb].cyc != last + 2)
      begin fails++; $display("FAIL sw_read: got n=%0d addr=%0h cyc=%0d required 1 0 %0d", r_a.size() - rb, r_a[rb].addr, r_a[rb].cyc, last + 2); end
    asserts++;
    if (done_q[db] != last + 4) begin fails++; $display("FAIL sw_done_lat: got cyc %0d required %0d", done_q[db], last + 4); end
    asserts++;
    if (derr_a[db] !== 1'b0) begin fails++; $display("FAIL sw_err: got %b required 0", derr_a[db]); end
    asserts++;
    if (w_b[wbb].addr != BASE_B) begin fails++; $display("FAIL sw_base_b: got %0h required %0h", w_b[wbb].addr, BASE_B); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[$];
    int last;
    words = {32'h11111111, 32'h22222222, 32'hFFFFFFFF};
    run_load(make_bytes(3, words), 0, -1, -1);
    last = acc_q[ab + 13];
    asserts++;
    if (w_a.size() - wb != 3 || r_a.size() - rb != 3)
      begin fails++; $display("FAIL b2b_counts: got w=%0d r=%0d required 3 3", w_a.size() - wb, r_a.size() - rb); end
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if (w_a[wb+k].addr != k || w_a[wb+k].data !== words[k] || w_a[wb+k].cyc != acc_q[ab+5+4*k] + 1)
        begin fails++; $display("FAIL b2b_write%0d: got %0h %h @%0d required %0h %h @%0d", k, w_a[wb+k].addr, w_a[wb+k].data, w_a[wb+k].cyc, k, words[k], acc_q[ab+5+4*k] + 1); end
      asserts++;
      if (r_a[rb+k].addr != k || r_a[rb+k].cyc != last + 2 + k)
        begin fails++; $display("FAIL b2b_read%0d: got %0h @%0d required %0h @%0d", k, r_a[rb+k].addr, r_a[rb+k].cyc, k, last + 2 + k); end
    end
    asserts++;
    if (done_q[db] != last + 6 || derr_a[db] !== 1'b0)
      begin fails++; $display("FAIL b2b_done: got cyc %0d err %b required %0d 0", done_q[db], derr_a[db], last + 6); end
  endtask

  task automatic test_early_term();
    logic [31:0] none[$];
    int lens[2];
    logic exp[2];
    int l;
    lens = '{0, 'h1001};
    exp  = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      run_load(make_bytes(lens[i], none), 0, -1, -1);
      l = acc_q[ab + 1];
      asserts++;
      if (w_a.size() != wb || r_a.size() != rb || w_b.size() != wbb || r_b.size() != rbb)
        begin fails++; $display("FAIL early_ram_%0h: got w=%0d r=%0d accesses required none", lens[i], w_a.size() - wb, r_a.size() - rb); end
      asserts++;
      if (done_q[db] != l + 2) begin fails++; $display("FAIL early_lat_%0h: got cyc %0d required %0d", lens[i], done_q[db], l + 2); end
      asserts++;
      if (derr_a[db] !== exp[i] || derr_b[dbb] !== exp[i])
        begin fails++; $display("FAIL early_err_%0h: got %b/%b required %b", lens[i], derr_a[db], derr_b[dbb], exp[i]); end
    end
  endtask

  task automatic test_wrap_mismatch();
    logic [31:0] words[$];
    int exp_addr;
    words = {$urandom(), $urandom() | 32'h1, $urandom()};
    run_load(make_bytes(3, words), 1, 1, -1);
    for (int k = 0; k < 3; k++) begin
      exp_addr = (BASE_B + k) % DEPTH;
      asserts++;
      if (w_b[wbb+k].addr != exp_addr || w_b[wbb+k].data !== words[k])
        begin fails++; $display("FAIL wrap_write%0d: got %0h %h required %0h %h", k, w_b[wbb+k].addr, w_b[wbb+k].data, exp_addr, words[k]); end
      asserts++;
      if (r_b[rbb+k].addr != exp_addr) begin fails++; $display("FAIL wrap_read%0d: got %0h required %0h", k, r_b[rbb+k].addr, exp_addr); end
    end
    asserts++;
    if (derr_a[db] !== 1'b1 || derr_b[dbb] !== 1'b1)
      begin fails++; $display("FAIL mismatch_err: got %b/%b required 1", derr_a[db], derr_b[dbb]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] words[$];
    int w0;
    mark();
    w0 = w_a.size();
    pulse_start();
    send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0); send_byte(8'hBB, 0, 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    asserts++;
    if ({s_ready_a, w_en_a, r_en_a, busy_a, done_a, err_a, busy_b} !== 7'b0 || w_addr_a !== '0 || w_data_a !== '0 || r_addr_a !== '0 || w_addr_b !== '0)
      begin fails++; $display("FAIL midrst_outputs: got ctrl %b addr %h data %h required all 0", {s_ready_a, w_en_a, r_en_a, busy_a, done_a, err_a, busy_b}, w_addr_a, w_data_a); end
    @(posedge clk); #1 rst_n = 1'b1;
    words = {$urandom()};
    run_load(make_bytes(1, words), 2, -1, -1);
    asserts++;
    if (w_a.size() - w0 != 1 || done_q.size() - db != 1)
      begin fails++; $display("FAIL midrst_counts: got w=%0d done=%0d required 1 1", w_a.size() - w0, done_q.size() - db); end
    asserts++;
    if (w_a[w0].addr != 0 || w_a[w0].data !== words[0] || w_b[wbb].addr != BASE_B || derr_a[db] !== 1'b0)
      begin fails++; $display("FAIL midrst_reload: got %0h %h err %b required 0 %h 0", w_a[w0].addr, w_a[w0].data, derr_a[db], words[0]); end
  endtask

  task automatic test_ignored();
    logic [31:0] words[$];
    int l;
    mark();
    s_valid = 1'b1; s_data = 8'($urandom());
    repeat (5) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (acc_q.size() != ab || s_ready_a !== 1'b0 || busy_a !== 1'b0)
      begin fails++; $display("FAIL idle_ignore: got %0d consumed ready=%b busy=%b required 0 0 0", acc_q.size() - ab, s_ready_a, busy_a); end
    @(posedge clk); #1 s_valid = 1'b0;
    words = {$urandom(), $urandom()};
    run_load(make_bytes(2, words), 0, -1, 4);
    asserts++;
    if (w_a.size() - wb != 2 || w_a[wb].data !== words[0] || w_a[wb+1].data !== words[1] || done_q.size() - db != 1 || derr_a[db] !== 1'b0)
      begin fails++; $display("FAIL start_in_data: got w=%0d %h %h done=%0d required 2 %h %h 1", w_a.size() - wb, w_a[wb].data, w_a[wb+1].data, done_q.size() - db, words[0], words[1]); end
    mark();
    pulse_start();
    send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    l = acc_q[ab + 1];
    s_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    asserts++;
    if (done_q.size() - db != 1 || done_q[db] != l + 2 || busy_a !== 1'b0)
      begin fails++; $display("FAIL start_in_done: got done@%0d busy=%b required done@%0d busy=0", done_q[db], busy_a, l + 2); end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    asserts++;
    if (busy_a !== 1'b1 || s_ready_a !== 1'b1)
      begin fails++; $display("FAIL restart: got busy=%b ready=%b required 1 1", busy_a, s_ready_a); end
    @(posedge clk); #1;
    send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [31:0] words[$];
      int n, corrupt, last, bad;
      logic exp_err;
      n = int'($urandom_range(6, 1));
      words = {};
      for (int k = 0; k < n; k++) words.push_back($urandom());
      corrupt = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n - 1, 0)) : -1;
      exp_err = (corrupt >= 0) && (words[corrupt] != 32'h0);
      run_load(make_bytes(n, words), 3, corrupt, -1);
      last = acc_q[ab + 1 + 4*n];
      asserts++;
      if (w_a.size() - wb != n || r_a.size() - rb != n || w_b.size() - wbb != n || r_b.size() - rbb != n)
        begin fails++; $display("FAIL rnd%0d_counts: got w=%0d r=%0d required %0d", it, w_a.size() - wb, r_a.size() - rb, n); end
      bad = 0;
      for (int k = 0; k < n; k++) begin
        if (w_a[wb+k].addr != k || w_a[wb+k].data !== words[k] || w_a[wb+k].cyc != acc_q[ab+5+4*k] + 1) bad++;
        if (w_b[wbb+k].addr != (BASE_B + k) % DEPTH || w_b[wbb+k].data !== words[k]) bad++;
        if (r_a[rb+k].addr != k || r_a[rb+k].cyc != last + 2 + k) bad++;
        if (r_b[rbb+k].addr != (BASE_B + k) % DEPTH) bad++;
      end
      asserts++;
      if (bad != 0) begin fails++; $display("FAIL rnd%0d_accesses: got %0d wrong write/read events required 0", it, bad); end
      asserts++;
      if (done_q[db] != last + 3 + n) begin fails++; $display("FAIL rnd%0d_done_lat: got cyc %0d required %0d", it, done_q[db], last + 3 + n); end
      asserts++;
      if (derr_a[db] !== exp_err || derr_b[dbb] !== exp_err)
        begin fails++; $display("FAIL rnd%0d_err: got %b/%b required %b", it, derr_a[db], derr_b[dbb], exp_err); end
    end
  endtask

  task automatic test_max_len();
    logic [31:0] words[$];
    int bad;
    for (int k = 0; k < DEPTH; k++) words.push_back($urandom());
    run_load(make_bytes(DEPTH, words), 0, -1, -1);
    asserts++;
    if (w_a.size() - wb != DEPTH || r_a.size() - rb != DEPTH)
      begin fails++; $display("FAIL max_counts: got w=%0d r=%0d required %0d", w_a.size() - wb, r_a.size() - rb, DEPTH); end
    bad = 0;
    for (int k = 0; k < DEPTH; k++)
      if (w_a[wb+k].addr != k || w_a[wb+k].data !== words[k] || w_b[wbb+k].addr != (BASE_B + k) % DEPTH) bad++;
    asserts++;
    if (bad != 0) begin fails++; $display("FAIL max_writes: got %0d wrong writes required 0", bad); end
    asserts++;
    if (derr_a[db] !== 1'b0 || derr_b[dbb] !== 1'b0)
      begin fails++; $display("FAIL max_err: got %b/%b required 0", derr_a[db], derr_b[dbb]); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_early_term();
    test_wrap_mismatch();
    test_reset_mid();
    test_ignored();
    test_random();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
